dbus_pair_sequencer: RTL



---
 rtl/dbus_pair_sequencer_pkg.sv | 22 ++
 rtl/dbus_lane_buf.sv | 45 ++++
 rtl/dbus_pair_sequencer.sv | 68 ++++++
 3 files changed

// File: rtl/dbus_pair_sequencer_pkg.sv
// dbus_pair_sequencer_pkg: bus request/response types and sequencer state encoding
package dbus_pair_sequencer_pkg;
    localparam int DBUS_ADDR_W = 32;
    localparam int DBUS_DATA_W = 32;
    typedef struct packed {
        logic                   valid;
        logic [DBUS_ADDR_W-1:0] addr;
        logic [1:0]             size;
        logic [3:0]             strobe;
        logic [DBUS_DATA_W-1:0] data;
    } dbus_req_t;
    typedef struct packed {
        logic                   addr_ok;
        logic                   data_ok;
        logic [DBUS_DATA_W-1:0] data;
    } dbus_resp_t;
    typedef struct packed {
        logic                     data_ok;
        logic [2*DBUS_DATA_W-1:0] data;
    } dbus_pair_resp_t;
    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ0, WAIT0, DONE} seq_state_t;
endpackage

// File: rtl/dbus_lane_buf.sv
// dbus_lane_buf: per-lane request latch and returned-data capture register
module dbus_lane_buf
    import dbus_pair_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_cap,
    input  dbus_req_t         i_req,
    input  logic [DATA_W-1:0] i_data,
    output dbus_req_t         o_req,
    output logic [DATA_W-1:0] o_data
);
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [3:0]        r_strobe;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    // loading a new request clears the previous response so a skipped lane reads back 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_addr   <= '0;
            r_size   <= '0;
            r_strobe <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else if (i_load) begin
            r_valid  <= i_req.valid;
            r_addr   <= i_req.addr;
            r_size   <= i_req.size;
            r_strobe <= i_req.strobe;
            r_wdata  <= i_req.data;
            r_rdata  <= '0;
        end else if (i_cap) begin
            r_rdata  <= i_data;
        end
    end
    assign o_req  = '{valid: r_valid, addr: r_addr, size: r_size, strobe: r_strobe, data: r_wdata};
    assign o_data = r_rdata;
endmodule

// File: rtl/dbus_pair_sequencer.sv
// dbus_pair_sequencer: issues the older then younger lane request on one data bus and packs both replies
module dbus_pair_sequencer
    import dbus_pair_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  dbus_req_t [1:0]       i_lreq,
    output dbus_pair_resp_t       o_lresp,
    output logic                  o_stall,
    output dbus_req_t             o_dreq,
    input  dbus_resp_t            i_dresp
);
    seq_state_t        r_state;
    dbus_req_t         w_req1;
    dbus_req_t         w_req0;
    dbus_req_t         w_sel;
    logic [DATA_W-1:0] w_data1;
    logic [DATA_W-1:0] w_data0;
    logic              w_load;
    logic              w_cap1;
    logic              w_cap0;
    logic              w_done;
    assign w_load = (r_state == IDLE) && (i_lreq[1].valid || i_lreq[0].valid);
    assign w_cap1 = i_dresp.data_ok && ((r_state == WAIT1) || ((r_state == REQ1) && i_dresp.addr_ok));
    assign w_cap0 = i_dresp.data_ok && ((r_state == WAIT0) || ((r_state == REQ0) && i_dresp.addr_ok));
    assign w_done = (r_state == DONE);
    dbus_lane_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lane1 (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_cap  (w_cap1),
        .i_req  (i_lreq[1]),
        .i_data (i_dresp.data),
        .o_req  (w_req1),
        .o_data (w_data1)
    );
    dbus_lane_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lane0 (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_cap  (w_cap0),
        .i_req  (i_lreq[0]),
        .i_data (i_dresp.data),
        .o_req  (w_req0),
        .o_data (w_data0)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:        r_state <= i_lreq[1].valid ? REQ1 : (i_lreq[0].valid ? REQ0 : IDLE);
                REQ1, WAIT1: r_state <= w_cap1 ? (w_req0.valid ? REQ0 : DONE) : (i_dresp.addr_ok ? WAIT1 : r_state);
                REQ0, WAIT0: r_state <= w_cap0 ? DONE : (i_dresp.addr_ok ? WAIT0 : r_state);
                default:     r_state <= IDLE;
            endcase
        end
    end
    // dreq is driven purely from latched lane buffers and state, never from dresp
    assign w_sel   = ((r_state == REQ1) || (r_state == WAIT1)) ? w_req1 : w_req0;
    assign o_dreq  = '{valid: w_sel.valid && ((r_state == REQ1) || (r_state == REQ0)),
                       addr: w_sel.addr, size: w_sel.size, strobe: w_sel.strobe, data: w_sel.data};
    assign o_lresp = '{data_ok: w_done, data: w_done ? {w_data0, w_data1} : '0};
    assign o_stall = (r_state == IDLE) ? (i_lreq[1].valid || i_lreq[0].valid) : !w_done;
endmodule
